// File: rtl/gol_blinker_tracker_if.sv
// Controller-side bundle for gol_blinker_tracker: cell writes, generation
// updates, count clearing, and the grid/count/handshake results.
// With BLOCK_DETECT_EN defined the bundle also carries block_count.
interface gol_blinker_tracker_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [RW-1:0]             row_select;
    logic [CW-1:0]             col_select;
    logic                      set_initial;
    logic                      new_state;
    logic                      enable_update;
    logic [ROWS-1:0][COLS-1:0] grid_next;
    logic                      clear_count;
    logic [ROWS-1:0][COLS-1:0] grid;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          frame_count;
    logic [CNT_W-1:0]          total_count;
`ifdef BLOCK_DETECT_EN
    logic [CNT_W-1:0]          block_count;

    modport master (
        output row_select, col_select, set_initial, new_state,
               enable_update, grid_next, clear_count,
        input  grid, busy, done, frame_count, total_count, block_count
    );
    modport slave (
        input  row_select, col_select, set_initial, new_state,
               enable_update, grid_next, clear_count,
        output grid, busy, done, frame_count, total_count, block_count
    );
`else
    modport master (
        output row_select, col_select, set_initial, new_state,
               enable_update, grid_next, clear_count,
        input  grid, busy, done, frame_count, total_count
    );
    modport slave (
        input  row_select, col_select, set_initial, new_state,
               enable_update, grid_next, clear_count,
        output grid, busy, done, frame_count, total_count
    );
`endif
endinterface

// File: rtl/gol_blinker_tracker.sv
// Life grid register (current + previous generation) with a sequential
// scan that counts blinker phase flips once per generation update.
// One centre cell is examined per cycle in row-major order; results are
// published in a single FINISH cycle with a done pulse.
// Optional macro BLOCK_DETECT_EN adds still-life 2x2 block counting.
module gol_blinker_tracker #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 8,
    parameter int WRAP  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    gol_blinker_tracker_if.slave  bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    // Bounded edges keep the outermost ring out of the centre set.
    localparam logic [RW-1:0] R_FIRST = RW'((WRAP != 0) ? 0 : 1);
    localparam logic [RW-1:0] R_LAST  = RW'((WRAP != 0) ? ROWS - 1 : ROWS - 2);
    localparam logic [CW-1:0] C_FIRST = CW'((WRAP != 0) ? 0 : 1);
    localparam logic [CW-1:0] C_LAST  = CW'((WRAP != 0) ? COLS - 1 : COLS - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t           state;
    grid_t            grid_q;
    grid_t            prev_q;
    logic [RW-1:0]    r_idx;
    logic [CW-1:0]    c_idx;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] frame_q;
    logic [CNT_W-1:0] total_q;
    logic             busy_q;
    logic             done_q;

    int   r_i;
    int   c_i;
    logic h_now, v_now, h_prev, v_prev, hit;

    // Cell lookup with signed offsets: wraps modulo the grid when WRAP is
    // set, otherwise anything outside the array reads as dead.
    function automatic logic cell_at(grid_t g, int r, int c);
        int rr = r;
        int cc = c;
        if (WRAP != 0) begin
            if (rr < 0)          rr = rr + ROWS;
            else if (rr >= ROWS) rr = rr - ROWS;
            if (cc < 0)          cc = cc + COLS;
            else if (cc >= COLS) cc = cc - COLS;
        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
            return 1'b0;
        end
        return g[RW'(rr)][CW'(cc)];
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    assign r_i = int'(r_idx);
    assign c_i = int'(c_idx);

    // Blinker test at the current centre: a three-cell bar that changed
    // orientation between the previous and the current generation.
    always_comb begin
        // NOTE: every signal here is assigned on every evaluation, so this
        // stays purely combinational; a missed path would infer a latch.
        h_now  = cell_at(grid_q, r_i, c_i - 1) & cell_at(grid_q, r_i, c_i) & cell_at(grid_q, r_i, c_i + 1);
        v_now  = cell_at(grid_q, r_i - 1, c_i) & cell_at(grid_q, r_i, c_i) & cell_at(grid_q, r_i + 1, c_i);
        h_prev = cell_at(prev_q, r_i, c_i - 1) & cell_at(prev_q, r_i, c_i) & cell_at(prev_q, r_i, c_i + 1);
        v_prev = cell_at(prev_q, r_i - 1, c_i) & cell_at(prev_q, r_i, c_i) & cell_at(prev_q, r_i + 1, c_i);
        hit    = (h_now & v_prev) | (v_now & h_prev);
    end

`ifdef BLOCK_DETECT_EN
    logic             sq_full;
    logic             ring_clear;
    logic             blk_hit;
    logic [CNT_W-1:0] blk_acc;
    logic [CNT_W-1:0] block_q;

    // Still-life block anchored at the centre: 2x2 alive in both
    // generations, and the surrounding 12-cell ring empty now.
    always_comb begin
        sq_full = 1'b1;
        for (int dr = 0; dr <= 1; dr++) begin
            for (int dc = 0; dc <= 1; dc++) begin
                sq_full = sq_full & cell_at(grid_q, r_i + dr, c_i + dc)
                                  & cell_at(prev_q, r_i + dr, c_i + dc);
            end
        end
        ring_clear = 1'b1;
        for (int k = -1; k <= 2; k++) begin
            ring_clear = ring_clear & ~cell_at(grid_q, r_i - 1, c_i + k)
                                    & ~cell_at(grid_q, r_i + 2, c_i + k);
        end
        for (int k = 0; k <= 1; k++) begin
            ring_clear = ring_clear & ~cell_at(grid_q, r_i + k, c_i - 1)
                                    & ~cell_at(grid_q, r_i + k, c_i + 2);
        end
        blk_hit = sq_full & ring_clear;
    end

    assign bus.block_count = block_q;
`endif

    // Control FSM plus all registered state and outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here samples the values from before the edge.
        if (!reset) begin
            // NOTE: the grid is a plain flop array, so it is cleared on reset
            // along with the rest of the state rather than left undefined.
            state   <= IDLE;
            grid_q  <= '0;
            prev_q  <= '0;
            r_idx   <= '0;
            c_idx   <= '0;
            acc     <= '0;
            frame_q <= '0;
            total_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BLOCK_DETECT_EN
            blk_acc <= '0;
            block_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.clear_count) total_q <= '0;

            case (state)
                IDLE: begin
                    if (bus.set_initial) begin
                        if (32'(bus.row_select) < ROWS && 32'(bus.col_select) < COLS)
                            grid_q[bus.row_select][bus.col_select] <= bus.new_state;
                    end else if (bus.enable_update) begin
                        prev_q  <= grid_q;
                        grid_q  <= bus.grid_next;
                        acc     <= '0;
                        r_idx   <= R_FIRST;
                        c_idx   <= C_FIRST;
                        busy_q  <= 1'b1;
                        state   <= SCAN;
`ifdef BLOCK_DETECT_EN
                        blk_acc <= '0;
`endif
                    end
                end
                SCAN: begin
                    acc <= sat_add(acc, CNT_W'(hit));
`ifdef BLOCK_DETECT_EN
                    blk_acc <= sat_add(blk_acc, CNT_W'(blk_hit));
`endif
                    if (c_idx == C_LAST) begin
                        c_idx <= C_FIRST;
                        if (r_idx == R_LAST) state <= FINISH;
                        else                 r_idx <= r_idx + 1'b1;
                    end else begin
                        c_idx <= c_idx + 1'b1;
                    end
                end
                FINISH: begin
                    // A coincident clear zeroes the running total before this frame is added.
                    frame_q <= acc;
                    total_q <= sat_add(bus.clear_count ? '0 : total_q, acc);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
`ifdef BLOCK_DETECT_EN
                    block_q <= blk_acc;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grid        = grid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frame_count = frame_q;
    assign bus.total_count = total_q;
endmodule

// File: tb/tb_gol_blinker_tracker.sv
// Bench for gol_blinker_tracker: three 16x16 instances (bounded/8-bit,
// toroidal/8-bit, bounded/2-bit) share one stimulus stream and each has
// its own scoreboard of expected frame/total/busy-length per done pulse.
module tb_gol_blinker_tracker;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int N_BOUNDED = (ROWS - 2) * (COLS - 2);
    localparam int N_TORUS   = ROWS * COLS;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;
    typedef struct {
        int frame;
        int total;
        int busy_len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_select;
    logic [3:0] col_select;
    logic       set_initial;
    logic       new_state;
    logic       enable_update;
    grid_t      grid_next;
    logic [2:0] clr;

    always #5 clk = ~clk;

    gol_blinker_tracker_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8)) bus0 ();
    gol_blinker_tracker_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8)) bus1 ();
    gol_blinker_tracker_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2)) bus2 ();

    assign bus0.row_select = row_select;   assign bus1.row_select = row_select;   assign bus2.row_select = row_select;
    assign bus0.col_select = col_select;   assign bus1.col_select = col_select;   assign bus2.col_select = col_select;
    assign bus0.set_initial = set_initial; assign bus1.set_initial = set_initial; assign bus2.set_initial = set_initial;
    assign bus0.new_state = new_state;     assign bus1.new_state = new_state;     assign bus2.new_state = new_state;
    assign bus0.enable_update = enable_update;
    assign bus1.enable_update = enable_update;
    assign bus2.enable_update = enable_update;
    assign bus0.grid_next = grid_next;     assign bus1.grid_next = grid_next;     assign bus2.grid_next = grid_next;
    assign bus0.clear_count = clr[0];      assign bus1.clear_count = clr[1];      assign bus2.clear_count = clr[2];

    gol_blinker_tracker #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8), .WRAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    gol_blinker_tracker #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8), .WRAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    gol_blinker_tracker #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2), .WRAP(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int   total_checks = 0;
    int   bad_checks   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    int   busy_cnt[3];
    int   tot_model[3];
    int   cnt_max[3] = '{255, 255, 3};
    int   n_len[3]   = '{N_BOUNDED + 1, N_TORUS + 1, N_BOUNDED + 1};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic push(input int d, input int raw, input bit clr_fin);
        exp_t e;
        e.frame = (raw > cnt_max[d]) ? cnt_max[d] : raw;
        tot_model[d] = (clr_fin ? 0 : tot_model[d]) + e.frame;
        if (tot_model[d] > cnt_max[d]) tot_model[d] = cnt_max[d];
        e.total = tot_model[d];
        e.busy_len = n_len[d];
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic observe(input int d, input logic busy, input logic done, input int fr, input int tot);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (busy) busy_cnt[d]++;
        if (done) begin
            case (d)
                0:       if (sb0.size() != 0) begin e = sb0.pop_front(); have = 1'b1; end
                1:       if (sb1.size() != 0) begin e = sb1.pop_front(); have = 1'b1; end
                default: if (sb2.size() != 0) begin e = sb2.pop_front(); have = 1'b1; end
            endcase
            check($sformatf("d%0d_done_expected", d), 256'(have), 256'(1));
            if (have) begin
                check($sformatf("d%0d_frame_count", d), 256'(fr), 256'(e.frame));
                check($sformatf("d%0d_total_count", d), 256'(tot), 256'(e.total));
                check($sformatf("d%0d_busy_cycles", d), 256'(busy_cnt[d]), 256'(e.busy_len));
            end
            busy_cnt[d] = 0;
        end
    endtask

    // Sample all instances on the falling edge, away from state changes.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
        end else begin
            observe(0, bus0.busy, bus0.done, int'(bus0.frame_count), int'(bus0.total_count));
            observe(1, bus1.busy, bus1.done, int'(bus1.frame_count), int'(bus1.total_count));
            observe(2, bus2.busy, bus2.done, int'(bus2.frame_count), int'(bus2.total_count));
        end
    end

    // ---------------- pattern helpers ----------------
    function automatic grid_t put(grid_t g, int r, int c);
        g[(r + ROWS) % ROWS][(c + COLS) % COLS] = 1'b1;
        return g;
    endfunction

    function automatic grid_t hbar(grid_t g, int r, int c);
        return put(put(put(g, r, c - 1), r, c), r, c + 1);
    endfunction

    function automatic grid_t vbar(grid_t g, int r, int c);
        return put(put(put(g, r - 1, c), r, c), r + 1, c);
    endfunction

    // ---------------- stimulus ----------------
    task automatic write_cell(input int r, input int c, input logic v);
        @(negedge clk);
        row_select  = 4'(r);
        col_select  = 4'(c);
        new_state   = v;
        set_initial = 1'b1;
        @(negedge clk);
        set_initial = 1'b0;
    endtask

    task automatic check_grids(input string tag, input grid_t want);
        check({tag, "_d0_grid"}, bus0.grid, want);
        check({tag, "_d1_grid"}, bus1.grid, want);
        check({tag, "_d2_grid"}, bus2.grid, want);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0_busy"},  256'(bus0.busy), 256'(0));
        check({tag, "_d0_done"},  256'(bus0.done), 256'(0));
        check({tag, "_d0_frame"}, 256'(bus0.frame_count), 256'(0));
        check({tag, "_d0_total"}, 256'(bus0.total_count), 256'(0));
        check({tag, "_d1_busy"},  256'(bus1.busy), 256'(0));
        check({tag, "_d1_total"}, 256'(bus1.total_count), 256'(0));
        check({tag, "_d2_busy"},  256'(bus2.busy), 256'(0));
        check({tag, "_d2_frame"}, 256'(bus2.frame_count), 256'(0));
        check_grids(tag, '0);
    endtask

    // Launch one generation update and wait until every scoreboard drains.
    task automatic run_update(input string tag, input grid_t g, input int raw_bounded,
                              input int raw_torus, input bit clr_fin, input bit poke);
        int e;
        @(negedge clk);
        grid_next     = g;
        enable_update = 1'b1;
        push(0, raw_bounded, clr_fin);
        push(1, raw_torus, clr_fin);
        push(2, raw_bounded, clr_fin);
        @(negedge clk);
        enable_update = 1'b0;
        e = 1;
        while ((sb0.size() + sb1.size() + sb2.size()) != 0 && e < 600) begin
            // e counts edges already taken since the update edge; the next edge is edge e.
            clr[0] = clr_fin && (e == n_len[0]);
            clr[1] = clr_fin && (e == n_len[1]);
            clr[2] = clr_fin && (e == n_len[2]);
            if (poke && e == 50) begin
                grid_next     = '1;
                enable_update = 1'b1;
            end
            if (poke && e == 51) begin
                enable_update = 1'b0;
                grid_next     = g;
                check_grids({tag, "_midscan"}, g);
            end
            @(negedge clk);
            e++;
        end
        clr = '0;
        check({tag, "_pending"}, 256'(sb0.size() + sb1.size() + sb2.size()), 256'(0));
        repeat (3) @(negedge clk);
        check({tag, "_idle_d1_busy"}, 256'(bus1.busy), 256'(0));
        check_grids(tag, g);
    endtask

    grid_t v8, h8, g;

    initial begin
        reset = 1'b0; row_select = '0; col_select = '0; set_initial = 1'b0;
        new_state = 1'b0; enable_update = 1'b0; grid_next = '0; clr = '0;
        for (int d = 0; d < 3; d++) tot_model[d] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        v8 = vbar('0, 8, 8);
        h8 = hbar('0, 8, 8);

        // Build a vertical blinker with single-cell writes.
        write_cell(7, 8, 1'b1);
        write_cell(8, 8, 1'b1);
        write_cell(9, 8, 1'b1);
        check_grids("writes", v8);

        // set_initial and enable_update together: the write wins, no scan.
        @(negedge clk);
        row_select = 4'd0; col_select = 4'd5; new_state = 1'b1;
        set_initial = 1'b1; enable_update = 1'b1; grid_next = '1;
        @(negedge clk);
        set_initial = 1'b0; enable_update = 1'b0;
        @(negedge clk);
        check("both_high_d0_busy", 256'(bus0.busy), 256'(0));
        check_grids("both_high", put(v8, 0, 5));
        write_cell(0, 5, 1'b0);

        // Single blinker flipping.
        run_update("flip_h", h8, 1, 1, 1'b0, 1'b0);
        run_update("flip_v", v8, 1, 1, 1'b0, 1'b0);

        // Second blinker at (4,4) joins one generation later.
        run_update("two_a", vbar(h8, 4, 4), 1, 1, 1'b0, 1'b0);
        run_update("two_b", hbar(v8, 4, 4), 2, 2, 1'b0, 1'b0);

        // Glider: two generations, no blinker anywhere.
        g = put(put(put(put(put('0, 1, 1), 2, 2), 2, 3), 3, 1), 3, 2);
        run_update("glider0", g, 0, 0, 1'b0, 1'b0);
        g = put(put(put(put(put('0, 1, 2), 2, 3), 3, 1), 3, 2), 3, 3);
        run_update("glider1", g, 0, 0, 1'b0, 1'b0);

        // Blinker straddling the corner: only the toroidal instance sees it.
        run_update("wrap_h", hbar('0, 0, 0), 0, 0, 1'b0, 1'b0);
        run_update("wrap_v", vbar('0, 0, 0), 0, 1, 1'b0, 1'b0);

        // Four blinkers in one frame: saturates the 2-bit instance.
        g = hbar(hbar(hbar(hbar('0, 4, 4), 4, 10), 10, 4), 10, 10);
        run_update("four_h", g, 0, 0, 1'b0, 1'b0);
        g = vbar(vbar(vbar(vbar('0, 4, 4), 4, 10), 10, 4), 10, 10);
        run_update("four_v", g, 4, 4, 1'b0, 1'b0);

        // clear_count during FINISH, plus an ignored enable_update mid-scan.
        g = hbar(hbar(hbar(hbar('0, 4, 4), 4, 10), 10, 4), 10, 10);
        run_update("clr_fin", g, 4, 4, 1'b1, 1'b1);

        // clear_count while idle.
        @(negedge clk);
        clr = '1;
        @(negedge clk);
        clr = '0;
        for (int d = 0; d < 3; d++) tot_model[d] = 0;
        check("clr_idle_d0_total", 256'(bus0.total_count), 256'(tot_model[0]));
        check("clr_idle_d1_total", 256'(bus1.total_count), 256'(tot_model[1]));
        check("clr_idle_d2_total", 256'(bus2.total_count), 256'(tot_model[2]));

        // Reset held for two cycles in the middle of a scan.
        @(negedge clk);
        grid_next = vbar('0, 4, 4);
        enable_update = 1'b1;
        @(negedge clk);
        enable_update = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_reset_d0_busy", 256'(bus0.busy), 256'(1));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midscan_reset");
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check("post_reset_d1_busy", 256'(bus1.busy), 256'(0));
        check_all_zero("post_reset");

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
